// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: FSM states, lamp codes, phase durations.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package traffic_pkg;

    // FSM state encodings
    localparam logic [2:0] S_NS_G  = 3'd0;
    localparam logic [2:0] S_NS_Y  = 3'd1;
    localparam logic [2:0] S_AR_A  = 3'd2;
    localparam logic [2:0] S_EW_G  = 3'd3;
    localparam logic [2:0] S_EW_Y  = 3'd4;
    localparam logic [2:0] S_AR_B  = 3'd5;
    localparam logic [2:0] S_FLASH = 3'd6;

    // Active-low lamp codes {red,yellow,green}
    localparam logic [2:0] LAMP_RED = 3'b011;
    localparam logic [2:0] LAMP_YEL = 3'b101;
    localparam logic [2:0] LAMP_GRN = 3'b110;
    localparam logic [2:0] LAMP_OFF = 3'b111;

    // Duration in ticks of the phase entered in state st; FLASH has no countdown.
    function automatic int unsigned phase_dur(input logic [2:0] st,
                                              input int unsigned green_s,
                                              input int unsigned yellow_s,
                                              input int unsigned allred_s);
        int unsigned d;
        d = 0;
        case (st)
            S_NS_G, S_EW_G: d = green_s;
            S_NS_Y, S_EW_Y: d = yellow_s;
            S_AR_A, S_AR_B: d = allred_s;
            default:        d = 0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_CYCLES clocks.
// Latency: tick is high while the counter sits at TICK_CYCLES-1 (combinational from the count).
// Backpressure: none; free-running.
module tick_gen #(
    parameter int TICK_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt;

    // Count 0..TICK_CYCLES-1 and wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-approach intersection controller with programmable phase times, ped shortening, night flash.
// Latency: lamps, countdown and ped_ack are registered; they change on the clock edge ending a tick cycle.
// Backpressure: none; ped_req is latched until served, mode_flash is sampled only at all-red expiry / in FLASH.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int TICK_CYCLES = 5_000_000,
    parameter int GREEN_S     = 10,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int MIN_GREEN_S = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_flash,
    input  logic             ped_req,
    output logic [2:0]       led_ns,
    output logic [2:0]       led_ew,
    output logic [CNT_W-1:0] countdown,
    output logic             tick,
    output logic             ped_ack
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GREEN_S);
    localparam logic [CNT_W-1:0] AR_C  = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic             tick_i;
    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ped_pending, pend_nxt;
    logic             flash_ph, flash_nxt;
    logic             enter_ar;
    logic [2:0]       ns_nxt, ew_nxt;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_i)
    );

    assign tick = tick_i;

    // Next state / phase timer: everything moves only on a tick; expiry takes priority over ped shortening
    always_comb begin
        state_nxt = state;
        cnt_nxt   = countdown;
        flash_nxt = flash_ph;
        enter_ar  = 1'b0;
        if (tick_i) begin
            if (state == S_FLASH) begin
                if (!mode_flash) begin
                    state_nxt = S_AR_B;
                    cnt_nxt   = AR_C;
                    enter_ar  = 1'b1;
                end else begin
                    flash_nxt = ~flash_ph;
                end
            end else if (countdown == ONE_C) begin
                if ((state == S_AR_A || state == S_AR_B) && mode_flash) begin
                    state_nxt = S_FLASH;
                    cnt_nxt   = '0;
                    flash_nxt = 1'b0;
                end else begin
                    state_nxt = (state == S_AR_B) ? S_NS_G : state + 3'd1;
                    cnt_nxt   = CNT_W'(phase_dur(state_nxt, GREEN_S, YELLOW_S, ALLRED_S));
                    enter_ar  = (state_nxt == S_AR_A) || (state_nxt == S_AR_B);
                end
            end else if ((state == S_NS_G || state == S_EW_G) && ped_pending && countdown > MIN_C) begin
                cnt_nxt = MIN_C;
            end else begin
                cnt_nxt = countdown - ONE_C;
            end
        end
    end

    // Request stays latched until an all-red entry serves it; a request on that same cycle re-arms
    assign pend_nxt = ped_req | (ped_pending & ~enter_ar);

    // Lamp decode from the next state so the lamps change on the same edge as the state
    always_comb begin
        ns_nxt = LAMP_RED;
        ew_nxt = LAMP_RED;
        case (state_nxt)
            S_NS_G:  ns_nxt = LAMP_GRN;
            S_NS_Y:  ns_nxt = LAMP_YEL;
            S_EW_G:  ew_nxt = LAMP_GRN;
            S_EW_Y:  ew_nxt = LAMP_YEL;
            S_FLASH: begin
                ns_nxt = flash_nxt ? LAMP_YEL : LAMP_OFF;
                ew_nxt = flash_nxt ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

    // State, timer, ped latch, flash phase and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_AR_B;
            countdown   <= AR_C;
            ped_pending <= 1'b0;
            flash_ph    <= 1'b0;
            ped_ack     <= 1'b0;
            led_ns      <= LAMP_RED;
            led_ew      <= LAMP_RED;
        end else begin
            state       <= state_nxt;
            countdown   <= cnt_nxt;
            ped_pending <= pend_nxt;
            flash_ph    <= flash_nxt;
            ped_ack     <= enter_ar & ped_pending;
            led_ns      <= ns_nxt;
            led_ew      <= ew_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Randomised bench for traffic_ctrl_param against a tick-level phase-table model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: n/a.
module tb_traffic_ctrl_param;

    localparam int TC = 4;
    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int A  = 1;
    localparam int M  = 2;
    localparam int W  = 8;

    localparam logic [2:0] RED = 3'b011;
    localparam logic [2:0] YEL = 3'b101;
    localparam logic [2:0] GRN = 3'b110;
    localparam logic [2:0] OFF = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode_flash = 1'b0;
    logic         ped_req = 1'b0;
    logic [2:0]   led_ns, led_ew;
    logic [W-1:0] countdown;
    logic         tick;
    logic         ped_ack;

    traffic_ctrl_param #(
        .TICK_CYCLES (TC),
        .GREEN_S     (G),
        .YELLOW_S    (Y),
        .ALLRED_S    (A),
        .MIN_GREEN_S (M),
        .CNT_W       (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_flash (mode_flash),
        .ped_req    (ped_req),
        .led_ns     (led_ns),
        .led_ew     (led_ew),
        .countdown  (countdown),
        .tick       (tick),
        .ped_ack    (ped_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase index 0..5 = NS green, NS yellow, all-red A, EW green, EW yellow, all-red B
    int m_presc, m_ph, m_remain;
    bit m_flash, m_fph, m_pend, m_ack;
    int dur[6] = '{G, Y, A, G, Y, A};

    task automatic model_reset();
        m_presc  = 0;
        m_ph     = 5;
        m_remain = A;
        m_flash  = 0;
        m_fph    = 0;
        m_pend   = 0;
        m_ack    = 0;
    endtask

    task automatic model_step(input bit req, input bit mf);
        bit t, entered, old;
        t       = (m_presc == TC - 1);
        m_presc = (m_presc + 1) % TC;
        entered = 0;
        old     = m_pend;
        if (t) begin
            if (m_flash) begin
                if (!mf) begin
                    m_flash  = 0;
                    m_ph     = 5;
                    m_remain = A;
                    entered  = 1;
                end else begin
                    m_fph = ~m_fph;
                end
            end else if (m_remain == 1) begin
                if ((m_ph == 2 || m_ph == 5) && mf) begin
                    m_flash  = 1;
                    m_fph    = 0;
                    m_remain = 0;
                end else begin
                    m_ph     = (m_ph + 1) % 6;
                    m_remain = dur[m_ph];
                    entered  = (m_ph == 2 || m_ph == 5);
                end
            end else if ((m_ph == 0 || m_ph == 3) && old && m_remain > M) begin
                m_remain = M;
            end else begin
                m_remain = m_remain - 1;
            end
        end
        m_ack  = entered && old;
        m_pend = req || (old && !entered);
    endtask

    function automatic logic [2:0] exp_lamp(input bit ns);
        if (m_flash) return m_fph ? YEL : OFF;
        if (ns) begin
            if (m_ph == 0) return GRN;
            if (m_ph == 1) return YEL;
        end else begin
            if (m_ph == 3) return GRN;
            if (m_ph == 4) return YEL;
        end
        return RED;
    endfunction

    task automatic check_all(input string pfx);
        chk({pfx, ".led_ns"},    32'(led_ns),    32'(exp_lamp(1'b1)));
        chk({pfx, ".led_ew"},    32'(led_ew),    32'(exp_lamp(1'b0)));
        chk({pfx, ".countdown"}, 32'(countdown), 32'(m_flash ? 0 : m_remain));
        chk({pfx, ".tick"},      32'(tick),      32'(m_presc == TC - 1));
        chk({pfx, ".ped_ack"},   32'(ped_ack),   32'(m_ack));
    endtask

    // One clock: drive at negedge, model, check after the edge, return at next negedge
    task automatic run_cycle(input bit req, input bit mf, input string pfx);
        ped_req    = req;
        mode_flash = mf;
        model_step(req, mf);
        @(posedge clk);
        #1;
        check_all(pfx);
        @(negedge clk);
    endtask

    initial begin
        bit mf;
        int guard;
        mf = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 249) == 0) mf = ~mf;
                run_cycle($urandom_range(0, 29) == 0, mf, "run");
            end
            // steer into EW yellow before the asynchronous reset
            mf = 0;
            guard = 0;
            while (!(m_ph == 4 && !m_flash) && guard < 400) begin
                run_cycle($urandom_range(0, 29) == 0, mf, "seek");
                guard++;
            end
            chk("seek_ew_y_reached", 32'(guard < 400), 32'(1));
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all("arst");
            @(negedge clk);
            ped_req = 1'b0;
            rst_n   = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
